// File: rtl/fpu_pkg.sv
// Shared FP writeback definitions: source indices, writable-register predicate, result request struct.
// Writable FP registers are 1..10, 30 and 31; every other address is a constant register.
package fpu_pkg;

   localparam int SRC_ADD = 0;
   localparam int SRC_MUL = 1;
   localparam int SRC_DIV = 2;

   localparam logic [4:0] FP_CONST_LO = 5'd11;
   localparam logic [4:0] FP_CONST_HI = 5'd29;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
   } fwb_req_t;

   function automatic logic fp_writable(input logic [4:0] addr);
      return (addr != 5'd0) && !((addr >= FP_CONST_LO) && (addr <= FP_CONST_HI));
   endfunction

endpackage

// File: rtl/fwb_rr_arb3.sv
// Three-way grant: round-robin from a last-grant pointer when FWB_RR_EN is defined,
// otherwise fixed priority div > mul > add. Combinational grant, one-hot or zero.
module fwb_rr_arb3
   import fpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req_i,
   output logic [2:0] gnt_o
);

`ifdef FWB_RR_EN
   logic [1:0] last_q, last_d;

   // Search order is last+1, last+2, last+3 (mod 3).
   always_comb begin
      gnt_o = 3'b000;
      unique case (last_q)
         2'd0: begin
            if      (req_i[1]) gnt_o = 3'b010;
            else if (req_i[2]) gnt_o = 3'b100;
            else if (req_i[0]) gnt_o = 3'b001;
         end
         2'd1: begin
            if      (req_i[2]) gnt_o = 3'b100;
            else if (req_i[0]) gnt_o = 3'b001;
            else if (req_i[1]) gnt_o = 3'b010;
         end
         default: begin
            if      (req_i[0]) gnt_o = 3'b001;
            else if (req_i[1]) gnt_o = 3'b010;
            else if (req_i[2]) gnt_o = 3'b100;
         end
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (gnt_o[SRC_ADD])      last_d = 2'd0;
      else if (gnt_o[SRC_MUL]) last_d = 2'd1;
      else if (gnt_o[SRC_DIV]) last_d = 2'd2;
   end

   // Reset to div so that add has first priority.
   always_ff @(posedge clk) begin
      if (!rst_n) last_q <= 2'd2;
      else        last_q <= last_d;
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   always_comb begin
      gnt_o = 3'b000;
      if      (req_i[SRC_DIV]) gnt_o[SRC_DIV] = 1'b1;
      else if (req_i[SRC_MUL]) gnt_o[SRC_MUL] = 1'b1;
      else if (req_i[SRC_ADD]) gnt_o[SRC_ADD] = 1'b1;
   end
`endif

endmodule

// File: rtl/fwb_arbiter.sv
// FP register-file writeback arbiter and RAW/WAW scoreboard (arbitration mode via FWB_RR_EN).
// Grant/ready combinational, write port registered one cycle after transfer; pending clears with the write.
module fwb_arbiter
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  chk_rs1,
   input  logic [4:0]  chk_rs2,
   input  logic [4:0]  chk_rd,
   output logic        hazard,
   input  logic        add_valid,
   input  logic [4:0]  add_rd,
   input  logic [31:0] add_data,
   input  logic        mul_valid,
   input  logic [4:0]  mul_rd,
   input  logic [31:0] mul_data,
   input  logic        div_valid,
   input  logic [4:0]  div_rd,
   input  logic [31:0] div_data,
   output logic        add_ready,
   output logic        mul_ready,
   output logic        div_ready,
   output logic        fwe,
   output logic [4:0]  rd_addr,
   output logic [31:0] wdata
);

   fwb_req_t    req_a [3];
   logic [2:0]  req_vec;
   logic [2:0]  gnt;
   logic [2:0]  xfer_vec;
   fwb_req_t    sel;
   logic        xfer;

   logic        fwe_q, fwe_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] pending_q, pending_d;

   always_comb begin
      req_a[SRC_ADD] = '{valid: add_valid, rd: add_rd, data: add_data};
      req_a[SRC_MUL] = '{valid: mul_valid, rd: mul_rd, data: mul_data};
      req_a[SRC_DIV] = '{valid: div_valid, rd: div_rd, data: div_data};
   end

   assign req_vec = {req_a[SRC_DIV].valid, req_a[SRC_MUL].valid, req_a[SRC_ADD].valid};

   fwb_rr_arb3 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (req_vec),
      .gnt_o (gnt)
   );

   // Ready is masked in reset so nothing is consumed that the reset would then lose.
   assign xfer_vec  = gnt & req_vec & {3{rst_n}};
   assign add_ready = xfer_vec[SRC_ADD];
   assign mul_ready = xfer_vec[SRC_MUL];
   assign div_ready = xfer_vec[SRC_DIV];
   assign xfer      = |xfer_vec;

   always_comb begin
      sel = '0;
      for (int i = 0; i < 3; i++) begin
         if (xfer_vec[i]) sel = req_a[i];
      end
   end

   always_comb begin
      fwe_d     = xfer && fp_writable(sel.rd);
      rd_addr_d = rd_addr_q;
      wdata_d   = wdata_q;
      if (xfer) begin
         rd_addr_d = sel.rd;
         wdata_d   = sel.data;
      end
   end

   // Clear from the write in flight, then set from issue so a same-address set wins.
   always_comb begin
      pending_d = pending_q;
      if (fwe_q) pending_d[rd_addr_q] = 1'b0;
      if (issue_valid && fp_writable(issue_rd)) pending_d[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwe_q     <= 1'b0;
         rd_addr_q <= 5'd0;
         wdata_q   <= 32'd0;
         pending_q <= 32'd0;
      end else begin
         fwe_q     <= fwe_d;
         rd_addr_q <= rd_addr_d;
         wdata_q   <= wdata_d;
         pending_q <= pending_d;
      end
   end

   assign hazard  = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];
   assign fwe     = fwe_q;
   assign rd_addr = rd_addr_q;
   assign wdata   = wdata_q;

endmodule
